// File: rtl/vocoder_pkg.sv
// Purpose: shared constants, types and helpers for the vocoder analysis
//          path envelope follower.
// Contents: sizing constants, sample/coefficient/envelope/band types,
//           FSM state type, saturating absolute-value helper.
package vocoder_pkg;

  localparam int NUM_BANDS    = 16;
  localparam int SAMPLE_WIDTH = 24;
  localparam int COEFF_WIDTH  = 32;
  localparam int FRAC_BITS    = 20;
  localparam int BAND_WIDTH   = $clog2(NUM_BANDS);

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic signed [COEFF_WIDTH-1:0]  coeff_t;
  typedef logic        [SAMPLE_WIDTH-1:0] env_t;
  typedef logic        [BAND_WIDTH-1:0]   band_t;

  localparam coeff_t  ONE_Q20    = coeff_t'(1 << FRAC_BITS);
  localparam env_t    ENV_MAX    = env_t'((1 << (SAMPLE_WIDTH - 1)) - 1);
  localparam sample_t SAMPLE_MIN = sample_t'(1 << (SAMPLE_WIDTH - 1));

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // |s| with the most negative code folded onto the largest positive code,
  // so the result always fits the envelope range.
  function automatic env_t abs_sat(input sample_t s);
    env_t r;
    if (s == SAMPLE_MIN) begin
      r = ENV_MAX;
    end else if (s[SAMPLE_WIDTH-1]) begin
      r = env_t'(-s);
    end else begin
      r = env_t'(s);
    end
    return r;
  endfunction

endpackage

// File: rtl/envelope_follower_if.sv
// Purpose: sample input / envelope output bundle of the envelope follower.
// Signals: sample_in, band_in, valid_in (toward the follower),
//          ready_out, env_out, band_out, valid_out, frame_done_out (from it).
// Modports: master = producer/consumer side, slave = envelope follower.
interface envelope_follower_if;
  import vocoder_pkg::*;

  sample_t sample_in;
  band_t   band_in;
  logic    valid_in;
  logic    ready_out;
  env_t    env_out;
  band_t   band_out;
  logic    valid_out;
  logic    frame_done_out;

  modport master (
    output sample_in, band_in, valid_in,
    input  ready_out, env_out, band_out, valid_out, frame_done_out
  );

  modport slave (
    input  sample_in, band_in, valid_in,
    output ready_out, env_out, band_out, valid_out, frame_done_out
  );

endinterface

// File: rtl/envelope_step.sv
// Purpose: one combinational update of the one-pole envelope smoother.
// Ports: r (rectified sample), e_old (current envelope), attack_coeff,
//        release_coeff (Q12.20) in; e_new (clamped updated envelope) out.
module envelope_step
  import vocoder_pkg::*;
(
  input  env_t   r,
  input  env_t   e_old,
  input  coeff_t attack_coeff,
  input  coeff_t release_coeff,
  output env_t   e_new
);

  localparam int PW = COEFF_WIDTH + SAMPLE_WIDTH + 1;
  localparam logic signed [PW-1:0] SUM_MAX = PW'(ENV_MAX);

  logic signed [SAMPLE_WIDTH:0] diff;
  coeff_t                       c;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         sum;

  always_comb begin
    diff = $signed({1'b0, r}) - $signed({1'b0, e_old});
    c    = (r > e_old) ? attack_coeff : release_coeff;
    prod = PW'(c) * PW'(diff);
    // Arithmetic shift floors toward -inf, so a decaying envelope always
    // moves down by at least one LSB until it reaches the target.
    sum  = (prod >>> FRAC_BITS) + $signed({{(PW - SAMPLE_WIDTH){1'b0}}, e_old});
    if (sum[PW-1]) begin
      e_new = '0;
    end else if (sum > SUM_MAX) begin
      e_new = ENV_MAX;
    end else begin
      e_new = sum[SAMPLE_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/envelope_follower.sv
// Purpose: per-band amplitude envelope tracker for time-multiplexed
//          band-filter samples (rectify + attack/release one-pole smoother).
// Ports: clk_in, rst_in (sync, active high), attack_coeff, release_coeff,
//        clear_in (zero all envelopes), bus (envelope_follower_if.slave).
//
// state    | meaning
// ST_CLEAR | sweeping env[cnt] to zero, input not ready
// ST_RUN   | accepting samples, two-stage update pipeline active
module envelope_follower
  import vocoder_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_in,
  input  coeff_t attack_coeff,
  input  coeff_t release_coeff,
  input  logic   clear_in,
  envelope_follower_if.slave bus
);

  state_t state;
  band_t  cnt;
  env_t   env_mem [NUM_BANDS];

  logic   s1_valid;
  env_t   s1_r;
  env_t   s1_e_old;
  band_t  s1_band;

  logic   accept;
  env_t   r_abs;
  env_t   e_fwd;
  env_t   e_new;

  envelope_step u_step (
    .r             (s1_r),
    .e_old         (s1_e_old),
    .attack_coeff  (attack_coeff),
    .release_coeff (release_coeff),
    .e_new         (e_new)
  );

  always_comb begin
    accept = bus.valid_in && bus.ready_out && !clear_in;
    r_abs  = abs_sat(bus.sample_in);
    // The stage-2 result for the same band is written on this very edge,
    // so the RAM still holds the stale value; take the fresh one instead.
    if (s1_valid && (s1_band == bus.band_in)) begin
      e_fwd = e_new;
    end else begin
      e_fwd = env_mem[bus.band_in];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= ST_CLEAR;
      cnt                <= '0;
      s1_valid           <= 1'b0;
      s1_r               <= '0;
      s1_e_old           <= '0;
      s1_band            <= '0;
      bus.ready_out      <= 1'b0;
      bus.valid_out      <= 1'b0;
      bus.env_out        <= '0;
      bus.band_out       <= '0;
      bus.frame_done_out <= 1'b0;
    end else begin
      bus.valid_out      <= 1'b0;
      bus.frame_done_out <= 1'b0;
      s1_valid           <= accept;
      if (accept) begin
        s1_r     <= r_abs;
        s1_e_old <= e_fwd;
        s1_band  <= bus.band_in;
      end
      case (state)
        ST_CLEAR: begin
          env_mem[cnt] <= '0;
          cnt          <= cnt + band_t'(1);
          if (cnt == band_t'(NUM_BANDS - 1)) begin
            state         <= ST_RUN;
            bus.ready_out <= 1'b1;
          end
        end
        ST_RUN: begin
          if (clear_in) begin
            // Stage-2 sample in flight is dropped here; stage 1 was already
            // refused through accept.
            state         <= ST_CLEAR;
            cnt           <= '0;
            bus.ready_out <= 1'b0;
          end else if (s1_valid) begin
            env_mem[s1_band]   <= e_new;
            bus.env_out        <= e_new;
            bus.band_out       <= s1_band;
            bus.valid_out      <= 1'b1;
            bus.frame_done_out <= (s1_band == band_t'(NUM_BANDS - 1));
          end
        end
        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_envelope_follower.sv
// Purpose: self-checking bench for envelope_follower: directed scenarios with
//          literal expectations plus randomized traffic against a behavioural
//          envelope model that is compared on every cycle.
module tb_envelope_follower;
  import vocoder_pkg::*;

  logic   clk_in = 1'b0;
  logic   rst_in = 1'b1;
  logic   clear_in = 1'b0;
  coeff_t attack_coeff = '0;
  coeff_t release_coeff = '0;

  envelope_follower_if bus();

  envelope_follower dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .attack_coeff  (attack_coeff),
    .release_coeff (release_coeff),
    .clear_in      (clear_in),
    .bus           (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam longint MAXV = (64'sd1 <<< (SAMPLE_WIDTH - 1)) - 1;

  function automatic longint model_abs(input longint s);
    longint r;
    r = (s < 0) ? -s : s;
    if (r > MAXV) r = MAXV;
    return r;
  endfunction

  function automatic longint model_step(input longint r, input longint e,
                                        input longint a, input longint rl);
    longint c, n;
    c = (r > e) ? a : rl;
    n = e + ((c * (r - e)) >>> FRAC_BITS);
    if (n < 0) n = 0;
    if (n > MAXV) n = MAXV;
    return n;
  endfunction

  longint m_env [NUM_BANDS];
  int     clr_left = 0;
  bit     prev_rst = 1'b1;
  bit     prev_clear = 1'b0;
  bit     ready_exp;
  bit     exp_valid = 1'b0;
  longint exp_env = 0;
  int     exp_band = 0;
  longint last_env = 0;
  int     last_band = 0;
  bit     pend = 1'b0;
  int     pend_band = 0;
  longint pend_r = 0;

  always @(negedge clk_in) begin
    if (prev_rst) clr_left = NUM_BANDS;
    else if (clr_left > 0) clr_left--;
    else if (prev_clear) clr_left = NUM_BANDS;
    ready_exp = (clr_left == 0);

    check("ready_out", longint'(bus.ready_out), longint'(ready_exp));
    check("valid_out", longint'(bus.valid_out), longint'(exp_valid));
    check("frame_done_out", longint'(bus.frame_done_out),
          longint'(exp_valid && (exp_band == NUM_BANDS - 1)));
    if (exp_valid) begin
      last_env  = exp_env;
      last_band = exp_band;
    end
    check("env_out", longint'(bus.env_out), last_env);
    check("band_out", longint'(bus.band_out), longint'(last_band));

    exp_valid = 1'b0;
    if (rst_in) begin
      pend = 1'b0;
      last_env = 0;
      last_band = 0;
      for (int i = 0; i < NUM_BANDS; i++) m_env[i] = 0;
    end else if (ready_exp && clear_in) begin
      pend = 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) m_env[i] = 0;
    end else if (pend) begin
      m_env[pend_band] = model_step(pend_r, m_env[pend_band],
                                    longint'(attack_coeff), longint'(release_coeff));
      exp_valid = 1'b1;
      exp_env   = m_env[pend_band];
      exp_band  = pend_band;
      pend      = 1'b0;
    end
    if (!rst_in && ready_exp && bus.valid_in && !clear_in) begin
      pend      = 1'b1;
      pend_band = int'(bus.band_in);
      pend_r    = model_abs(longint'(bus.sample_in));
    end
    prev_rst   = rst_in;
    prev_clear = clear_in;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int b, input longint s, input bit clr);
    @(posedge clk_in);
    #1;
    bus.valid_in  = v;
    bus.band_in   = band_t'(b);
    bus.sample_in = sample_t'(s);
    clear_in      = clr;
  endtask

  task automatic set_coeff(input longint a, input longint r);
    @(posedge clk_in);
    #1;
    attack_coeff  = coeff_t'(a);
    release_coeff = coeff_t'(r);
  endtask

  task automatic expect_out(input string name, input int b, input longint e, input bit fd);
    @(negedge clk_in);
    check({name, "_valid"}, longint'(bus.valid_out), 1);
    check({name, "_band"}, longint'(bus.band_out), longint'(b));
    check({name, "_env"}, longint'(bus.env_out), e);
    check({name, "_frame"}, longint'(bus.frame_done_out), longint'(fd));
  endtask

  task automatic send_and_check(input string name, input int b, input longint s,
                                input longint e, input bit fd);
    drive(1'b1, b, s, 1'b0);
    drive(1'b0, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 1'b0);
    expect_out(name, b, e, fd);
  endtask

  // Counts not-ready cycles from the next falling edge, bounded.
  task automatic count_low(output int lows, output int pulses);
    lows = 0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (bus.ready_out) break;
      lows++;
      if (bus.valid_out) pulses++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, pulses;
    int b, last_b;
    longint s;
    bus.valid_in  = 1'b0;
    bus.band_in   = '0;
    bus.sample_in = '0;

    check("pin_model_attack", model_step(64'h300000, 0, 1 << 20, 0), 64'h300000);
    check("pin_model_release", model_step(0, 64'h300000, 0, 1 << 19), 64'h180000);
    check("pin_model_abs_min", model_abs(-64'sh800000), 64'h7FFFFF);
    check("pin_model_clamp", model_step(64'h7FFFFF, 0, 2 << 20, 0), 64'h7FFFFF);
    check("pin_model_floor", model_step(0, 3, 0, 1 << 19), 1);

    // 1. reset
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    count_low(lows, pulses);
    check("reset_ready_low", longint'(lows), 16);
    check("reset_no_valid", longint'(pulses), 0);

    // 2. attack jump
    set_coeff(1 << 20, 0);
    send_and_check("attack_jump", 3, -64'sh300000, 64'h300000, 1'b0);

    // 3. release halving
    set_coeff(1 << 20, 1 << 19);
    send_and_check("release1", 3, 0, 64'h180000, 1'b0);
    send_and_check("release2", 3, 0, 64'h0C0000, 1'b0);
    send_and_check("release3", 3, 0, 64'h060000, 1'b0);

    // 4. same-band back-to-back
    set_coeff(1 << 19, 1 << 19);
    drive(1'b1, 5, 64'h100000, 1'b0);
    drive(1'b1, 5, 64'h100000, 1'b0);
    drive(1'b0, 0, 0, 1'b0);
    expect_out("fwd_first", 5, 64'h080000, 1'b0);
    drive(1'b0, 0, 0, 1'b0);
    expect_out("fwd_second", 5, 64'h0C0000, 1'b0);
    send_and_check("band3_independent", 3, 64'h060000, 64'h060000, 1'b0);

    // 5. saturation and frame marker
    set_coeff(1 << 20, 1 << 19);
    send_and_check("sat_band15", 15, -64'sh800000, 64'h7FFFFF, 1'b1);
    send_and_check("band14_no_frame", 14, 64'h123456, 64'h123456, 1'b0);

    // 6. clear mid-stream
    drive(1'b1, 3, 64'h200000, 1'b0);
    drive(1'b1, 3, 64'h100000, 1'b1);
    drive(1'b0, 0, 0, 1'b0);
    count_low(lows, pulses);
    check("clear_ready_low", longint'(lows), 16);
    check("clear_no_valid", longint'(pulses), 0);
    set_coeff(1 << 20, 1 << 19);
    send_and_check("after_clear", 3, 0, 0, 1'b0);

    // randomized traffic, compared every cycle by the model process
    last_b = 0;
    for (int n = 0; n < 2500; n++) begin
      b = ($urandom_range(0, 3) == 0) ? last_b : int'($urandom_range(0, NUM_BANDS - 1));
      case ($urandom_range(0, 5))
        0: s = -64'sh800000;
        1: s = 64'h7FFFFF;
        2: s = longint'($urandom_range(0, 2000)) - 1000;
        default: s = longint'($signed(24'($urandom)));
      endcase
      drive($urandom_range(0, 9) < 7, b, s, $urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 9) == 0) attack_coeff = coeff_t'($urandom_range(0, 2 << 20));
        else attack_coeff = coeff_t'($urandom_range(0, 1 << 20));
        release_coeff = coeff_t'($urandom_range(0, 1 << 20));
      end
      last_b = b;
    end
    repeat (4) drive(1'b0, 0, 0, 1'b0);
    @(negedge clk_in);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/envelope_follower.md
Name: envelope_follower

Overview:
- Downstream stage of the band-pass biquad filters in the vocoder analysis path.
- Consumes the filtered 24-bit band samples, time-multiplexed across all bands, and tracks a per-band amplitude envelope.
- Envelope is full-wave rectification followed by a one-pole smoother with separate attack and release coefficients.
- The synthesis stage uses the envelopes as per-band gains on the carrier.

Parameters:
- NUM_BANDS, 16, number of bands time-multiplexed through the block.
- SAMPLE_WIDTH, 24, signed input sample width and unsigned envelope width.
- COEFF_WIDTH, 32, coefficient width.
- FRAC_BITS, 20, fractional bits of coefficients (Q12.20; 1.0 = 1<<20).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- attack_coeff  in  COEFF_WIDTH  signed Q12.20 smoothing factor used when |x| > envelope; valid range 0..1<<20.
- release_coeff  in  COEFF_WIDTH  signed Q12.20 smoothing factor used when |x| <= envelope; valid range 0..1<<20.
- clear_in  in  1  one-cycle request to zero all envelopes.
- sample_in  in  SAMPLE_WIDTH  signed band-filter output.
- band_in  in  $clog2(NUM_BANDS)  band index of sample_in.
- valid_in  in  1  sample_in/band_in valid; accepted only when ready_out=1.
- ready_out  out  1  high in RUN state.
- env_out  out  SAMPLE_WIDTH  unsigned updated envelope.
- band_out  out  $clog2(NUM_BANDS)  band index of env_out.
- valid_out  out  1  env_out/band_out valid, one-cycle pulse per accepted sample.
- frame_done_out  out  1  pulses with valid_out when band_out == NUM_BANDS-1.

Behaviour:
- Reset (rst_in=1 at posedge): state=CLEAR, clear counter=0, all pipeline valid bits=0.
  - Outputs at reset: ready_out=0, valid_out=0, env_out=0, band_out=0, frame_done_out=0.
- FSM has two states: CLEAR and RUN.
- CLEAR:
  - Writes env[cnt]=0 each cycle and increments cnt.
  - After the write of cnt=NUM_BANDS-1, the next state is RUN.
  - ready_out is low for exactly NUM_BANDS cycles after reset or clear.
- RUN:
  - ready_out=1 (registered).
  - clear_in=1 moves the state to CLEAR with cnt=0.
  - clear_in has priority: a valid_in in the same cycle is dropped.
  - All in-flight stage-1/stage-2 samples are discarded: no valid_out and no writeback.
- clear_in is ignored while in CLEAR (the sweep does not restart).
- Accept condition: valid_in && ready_out && !clear_in.
- Stage 1 (registered):
  - r = |sample_in|, saturated so that -2^23 gives 2^23-1.
  - Latch band_in.
  - Read env[band_in], with forwarding: if stage 2 writes the same band this cycle, use the stage-2 result.
- Stage 2 (registered):
  - diff = r - e_old, as a (SAMPLE_WIDTH+1)-bit signed value.
  - c = (r > e_old) ? attack_coeff : release_coeff; coefficients are sampled in stage 2.
  - prod = c * diff, full width (COEFF_WIDTH+SAMPLE_WIDTH+1 signed).
  - e_new = e_old + (prod >>> FRAC_BITS); the arithmetic shift floors.
  - Clamp e_new to [0, 2^SAMPLE_WIDTH-1 >> 1]: below 0 becomes 0, above 2^23-1 becomes 2^23-1.
  - Write env[band]=e_new; drive env_out=e_new, band_out=band, valid_out=1.
- Latency:
  - valid_in at edge t produces valid_out high in the cycle after edge t+2 (2-cycle latency).
  - Full throughput of 1 sample/cycle, any band order.
  - Back-to-back samples of the same band are exact via forwarding.
- No backpressure on the output side; the consumer must accept every valid_out.
- valid_out=0 holds env_out/band_out at their last values; frame_done_out=0 whenever valid_out=0.
- Coefficient semantics:
  - 1<<20 makes the envelope jump to r.
  - 0 holds the envelope.
  - Values > 1<<20 are out of range, but clamping still keeps the output legal.

Decomposition:
- vocoder_pkg holds:
  - SAMPLE_WIDTH, COEFF_WIDTH, FRAC_BITS, NUM_BANDS constants;
  - sample_t (signed 24), coeff_t (signed 32), env_t (unsigned 24), band_t typedefs;
  - ONE_Q20 = 1<<20.
- One combinational sub-module, envelope_step: inputs r, e_old, attack, release; output e_new.
  - It performs compare, subtract, multiply, shift and clamp.
  - It is unit-tested separately.
- State RAM, forwarding, FSM and pipeline stay in envelope_follower.

Test Plan:
1. Reset: hold rst_in 2 cycles, release.
   - ready_out=0 for exactly 16 cycles, then 1.
   - All outputs 0 throughout.
2. Attack jump: attack=1<<20, band 3, sample -0x300000.
   - Two cycles later: valid_out=1, band_out=3, env_out=0x300000.
3. Release: release=1<<19, then band 3 sample 0.
   - env_out=0x180000.
   - Repeating on band 3 gives 0x0C0000, then 0x060000.
4. Same-band forwarding: attack=1<<19, band 5 samples 0x100000 on consecutive cycles.
   - env_out=0x080000, then 0x0C0000 on consecutive cycles.
   - Band 5 stays independent of band 3.
5. Saturation and frame: attack=1<<20, band 15 sample -0x800000.
   - env_out=0x7FFFFF with frame_done_out=1.
   - Band 14 does not pulse frame_done_out.
6. Clear mid-stream: send band 3 sample in the cycle before clear_in, then a valid_in together with clear_in.
   - Neither produces valid_out.
   - ready_out low for 16 cycles.
   - Then release=1<<19, band 3 sample 0 gives env_out=0.
